// File: rtl/spi_responder_pkg.sv
// Shared SPI definitions: default word size, responder FSM states and sizing helpers.
package spi_responder_pkg;

  localparam int SPI_WORD_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } spi_state_e;

  // Bit counter must hold the value WORD_BITS itself, not only WORD_BITS-1.
  function automatic int cnt_width(input int word_bits);
    return $clog2(word_bits) + 1;
  endfunction

endpackage

// File: rtl/spi_responder_if.sv
// Bundle of the MCU-facing SPI pins and the transmit word handshake.
interface spi_responder_if #(
  parameter int WORD_BITS = 16
) ();
  logic                 sck;
  logic                 cs;
  logic [WORD_BITS-1:0] txData;
  logic                 txValid;
  logic                 txReady;
  logic                 sdo;
  logic                 busy;
  logic                 txDone;
  logic                 txUnderrun;
  logic                 txAbort;

  modport master (
    output sck, cs, txData, txValid,
    input  txReady, sdo, busy, txDone, txUnderrun, txAbort
  );

  modport slave (
    input  sck, cs, txData, txValid,
    output txReady, sdo, busy, txDone, txUnderrun, txAbort
  );
endinterface

// File: rtl/spi_responder_sync.sv
// Two-flop synchronizer for one asynchronous input into the clk domain.
module spi_responder_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 transmit responder: shifts one held word out on sdo per cs window,
// reporting completion, underrun and early abort as single-cycle pulses.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int                   WORD_BITS = SPI_WORD_BITS,
  parameter logic [WORD_BITS-1:0] IDLE_WORD = '0
) (
  input  logic           clk,
  input  logic           reset,
  spi_responder_if.slave bus
);
  localparam int                 CNT_W    = cnt_width(WORD_BITS);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(WORD_BITS);

  // index 0 = sck, index 1 = cs
  logic [1:0] raw, syn;
  assign raw = {bus.cs, bus.sck};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    spi_responder_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (raw[gi]),
      .q_o   (syn[gi])
    );
  end

  spi_state_e           state_q, state_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sck_prev_q, cs_prev_q;
  logic [1:0]           vld_pipe_q;
  logic                 cs_arm_q, cs_arm_d;
  logic                 sdo_q, sdo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 underrun_q, underrun_d;
  logic                 abort_q, abort_d;

  logic sck_rise, sck_fall, cs_rise, cs_fall, accept;

  // cs_arm_q blocks a cs that is already high out of reset from starting a
  // transaction; it arms only once cs has truly been observed low, which
  // needs the synchronizer pipeline refilled (vld_pipe_q) first.
  assign sck_rise = syn[0] & ~sck_prev_q;
  assign sck_fall = ~syn[0] & sck_prev_q;
  assign cs_rise  = syn[1] & ~cs_prev_q & cs_arm_q;
  assign cs_fall  = ~syn[1] & cs_prev_q;
  assign accept   = bus.txValid & ~hold_full_q;
  assign cs_arm_d = cs_arm_q | (vld_pipe_q[1] & ~syn[1]);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_rise) begin
          shift_d     = hold_full_q ? hold_q : IDLE_WORD;
          underrun_d  = ~hold_full_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // cs fall wins over a coincident sck edge
        if (cs_fall) begin
          abort_d = 1'b1;
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_FULL) begin
            done_d  = 1'b1;
            shift_d = '0;
            state_d = ST_HOLD;
          end
        end else if (sck_fall) begin
          shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
        end
      end
      ST_HOLD: begin
        if (cs_fall) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the FSM so a same-cycle start consumes the old contents
    // and the freshly accepted word stays held for the next transaction.
    if (accept) begin
      hold_d      = bus.txData;
      hold_full_d = 1'b1;
    end

    sdo_d  = (state_d == ST_SHIFT) ? shift_d[WORD_BITS-1] : 1'b0;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      vld_pipe_q  <= '0;
      cs_arm_q    <= 1'b0;
      sdo_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      sck_prev_q  <= syn[0];
      cs_prev_q   <= syn[1];
      vld_pipe_q  <= {vld_pipe_q[0], 1'b1};
      cs_arm_q    <= cs_arm_d;
      sdo_q       <= sdo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.txReady    = ~hold_full_q;
  assign bus.sdo        = sdo_q;
  assign bus.busy       = busy_q;
  assign bus.txDone     = done_q;
  assign bus.txUnderrun = underrun_q;
  assign bus.txAbort    = abort_q;
endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: acts as a mode-0 SPI master and word producer.
module tb_spi_responder;
  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nfail = 0;
  int   n_done = 0, n_under = 0, n_abort = 0;
  int   d0, u0, a0;
  logic [31:0] rx, rxa, rxb;

  always #5 clk = ~clk;

  spi_responder_if #(.WORD_BITS(16)) bus ();

  spi_responder #(.WORD_BITS(16), .IDLE_WORD(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.txDone === 1'b1)     n_done++;
    if (bus.txUnderrun === 1'b1) n_under++;
    if (bus.txAbort === 1'b1)    n_abort++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    d0 = n_done; u0 = n_under; a0 = n_abort;
  endtask

  task automatic load(input logic [15:0] w);
    @(negedge clk);
    chk("load_ready", {31'd0, bus.txReady}, 32'd1);
    bus.txData  = w;
    bus.txValid = 1'b1;
    @(negedge clk);
    bus.txValid = 1'b0;
  endtask

  task automatic cs_start();
    @(negedge clk);
    bus.cs = 1'b1;
    clks(8);
  endtask

  task automatic cs_end();
    bus.cs = 1'b0;
    clks(8);
  endtask

  // MCU samples sdo just before each sck rise
  task automatic shift_bits(input int n, output logic [31:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[30:0], bus.sdo};
      bus.sck = 1'b1;
      clks(8);
      bus.sck = 1'b0;
      clks(8);
    end
  endtask

  task automatic xfer(input int n, output logic [31:0] r);
    cs_start();
    shift_bits(n, r);
    cs_end();
  endtask

  initial begin
    bus.sck = 1'b0; bus.cs = 1'b0; bus.txData = '0; bus.txValid = 1'b0;
    reset = 1'b1;
    clks(4);
    reset = 1'b0;
    clks(4);

    chk("rst_ready", {31'd0, bus.txReady}, 32'd1);
    chk("rst_sdo", {31'd0, bus.sdo}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_pulses", n_done + n_under + n_abort, 32'd0);

    // normal word
    snap();
    load(16'hA55A);
    chk("a55a_held", {31'd0, bus.txReady}, 32'd0);
    xfer(16, rx);
    chk("a55a_data", rx, 32'h0000A55A);
    chk("a55a_done", n_done - d0, 32'd1);
    chk("a55a_under", n_under - u0, 32'd0);
    chk("a55a_busy", {31'd0, bus.busy}, 32'd0);
    chk("a55a_ready", {31'd0, bus.txReady}, 32'd1);

    // underrun
    snap();
    xfer(16, rx);
    chk("udr_data", rx, 32'h0);
    chk("udr_under", n_under - u0, 32'd1);
    chk("udr_done", n_done - d0, 32'd1);

    // abort after 5 rises
    snap();
    load(16'hFFFF);
    xfer(5, rx);
    chk("abt_bits", rx, 32'h1F);
    chk("abt_abort", n_abort - a0, 32'd1);
    chk("abt_done", n_done - d0, 32'd0);
    chk("abt_ready", {31'd0, bus.txReady}, 32'd1);
    snap();
    xfer(16, rx);
    chk("abt_next_data", rx, 32'h0);
    chk("abt_next_under", n_under - u0, 32'd1);
    chk("abt_next_abort", n_abort - a0, 32'd0);

    // accept in the same cycle as cs-rise detection
    snap();
    @(negedge clk);
    bus.cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.txData  = 16'h1234;
    bus.txValid = 1'b1;
    @(negedge clk);
    bus.txValid = 1'b0;
    clks(6);
    shift_bits(16, rx);
    cs_end();
    chk("same_data", rx, 32'h0);
    chk("same_under", n_under - u0, 32'd1);
    chk("same_held", {31'd0, bus.txReady}, 32'd0);
    snap();
    xfer(16, rx);
    chk("same_next_data", rx, 32'h00001234);
    chk("same_next_under", n_under - u0, 32'd0);

    // reset mid-transaction with cs held high
    load(16'hC3C3);
    cs_start();
    shift_bits(8, rx);
    chk("mid_bits", rx, 32'hC3);
    reset = 1'b1;
    clks(3);
    reset = 1'b0;
    clks(4);
    snap();
    chk("mid_ready", {31'd0, bus.txReady}, 32'd1);
    chk("mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_sdo", {31'd0, bus.sdo}, 32'd0);
    shift_bits(4, rx);
    chk("mid_nostart_sdo", rx, 32'h0);
    chk("mid_nostart_busy", {31'd0, bus.busy}, 32'd0);
    cs_end();
    chk("mid_pulses", (n_done - d0) + (n_under - u0) + (n_abort - a0), 32'd0);
    xfer(16, rx);
    chk("mid_after_data", rx, 32'h0);
    chk("mid_after_under", n_under - u0, 32'd1);

    // word loaded during SHIFT, then 20 sck cycles
    load(16'h8001);
    snap();
    cs_start();
    shift_bits(4, rxa);
    load(16'h0F0F);
    chk("ovr_held", {31'd0, bus.txReady}, 32'd0);
    shift_bits(16, rxb);
    cs_end();
    chk("ovr_data20", {12'd0, rxa[3:0], rxb[15:0]}, 32'h00080010);
    chk("ovr_done", n_done - d0, 32'd1);
    chk("ovr_abort", n_abort - a0, 32'd0);
    snap();
    xfer(16, rx);
    chk("ovr_next_data", rx, 32'h00000F0F);
    chk("ovr_next_under", n_under - u0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
